mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

M-stage data-memory access controller for the P7 pipelined MIPS core. Converts one load/store request per instruction into a multi-cycle bus transaction with byte enables, stalls the pipeline until the bus acknowledges, and hands the raw aligned 32-bit read word plus the low address bits to the downstream load-extension stage (lb/lh/lw sign-extend). It also detects misaligned accesses (AdEL/AdES) and bus timeouts for the CP0 exception logic.

## Interface
- TIMEOUT, 255: maximum bus_req cycles without bus_ack before abort; counter width $clog2(TIMEOUT+1)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- req_valid  in  1  M-stage instruction performs a memory access; held high while stalled
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rt), low-aligned
- flush  in  1  pipeline flush (exception/eret); cancels current instruction
- stall  out  1  freeze F/D/E/M stages
- bus_req  out  1  transaction request, registered
- bus_we  out  1  write strobe, registered
- bus_addr  out  32  {req_addr[31:2],2'b00}, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  transaction complete, one cycle
- bus_rdata  in  32  read word, valid with bus_ack
- rsp_valid  out  1  one-cycle pulse: rsp_rdata valid, instruction may advance
- rsp_rdata  out  32  raw read word for the load-extension stage (0 for stores)
- rsp_addr_lo  out  2  req_addr[1:0] of the completed access
- exc_adel / exc_ades  out  1 each  misaligned load / store, combinational
- exc_bus  out  1  one-cycle pulse: bus timeout

## Operation
- States: IDLE, BUSY, RESP. Reset: state IDLE, all outputs and counter 0, discard 0.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; byte always aligned.
- IDLE, req_valid, !flush, misaligned: exc_adel (load) or exc_ades (store) high same cycle, stall 0, no bus transaction, stay IDLE.
- IDLE, req_valid, !flush, aligned: latch request, go BUSY; bus_req and bus fields valid from next cycle.
- IDLE with flush: request ignored, no exception.
- Byte enables: byte 4'b0001<<addr[1:0], wdata {4{wdata[7:0]}}; half addr[1]?1100:0011, wdata {2{wdata[15:0]}}; word 1111, wdata unchanged. Loads drive the same be.
- BUSY: bus_req held, fields stable, counter increments each cycle. bus_ack: capture bus_rdata (loads), clear bus_req, go RESP. Counter reaches TIMEOUT without ack: clear bus_req, flag timeout, go RESP. Ack in the timeout cycle: ack wins.
- RESP (one cycle): rsp_valid=1 (normal) or exc_bus=1 (timeout), unless discard set, then both 0. Requests ignored. Next state IDLE.
- flush while BUSY: set discard; bus transaction still completes (no bus abort). Discard clears on RESP exit.
- stall = (IDLE & req_valid & aligned & !flush) | BUSY. Low in RESP.

## Timing
- Request accepted cycle T; bus_req high T+1 onward.
- Zero-wait bus (ack at T+1): rsp_valid at T+2; stall high T, T+1, low T+2.
- k wait cycles: rsp_valid at T+2+k.
- Timeout: bus_req high T+1..T+TIMEOUT; exc_bus at T+TIMEOUT+1.
- Back-to-back: next request acceptable earliest at T+3 (IDLE).
- reset low mid-BUSY: bus_req drops asynchronously; no rsp_valid, no exc_bus afterwards.
- rsp_rdata/rsp_addr_lo hold last value until next response.

## Test plan
- lw 0x0000_1004, ack at first bus_req cycle, rdata 0xDEADBEEF -> bus_addr 0x1004, be 1111, rsp_valid at T+2 with 0xDEADBEEF, rsp_addr_lo 00, stall high 2 cycles.
- sb addr 0x1003 wdata 0x000000A5, ack after 3 waits -> bus_we 1, be 1000, wdata 0xA5A5A5A5, rsp_valid at T+5.
- lh addr 0x1001 -> exc_adel same cycle, stall 0, bus_req never asserted; sw addr 0x1002 -> exc_ades.
- TIMEOUT=4, lw with no ack -> bus_req 4 cycles, exc_bus pulse at T+5, rsp_valid never, returns IDLE.
- lw accepted, flush at T+1, ack at T+2 -> transaction completes, no rsp_valid/exc_bus, stall low at T+3.
- reset low during BUSY -> bus_req, stall 0 immediately; after release a new sh addr 0x2002 wdata 0x1234 gives be 1100, wdata 0x12341234.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// M-stage load/store bus controller: one request -> registered bus transaction, raw read word back.
// Latency: bus_req at T+1, rsp_valid at T+2+waits; stalls the pipeline until the bus acks or times out.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_addr_lo,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          timed_out;
  logic          discard;
  logic [1:0]    addr_lo_q;
  logic          misaligned;
  logic          req_live;
  logic          accept;
  logic          expire;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = |req_addr[1:0];
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = req_wdata;
    case (req_size)
      2'b00: begin
        be_nxt    = 4'b0001 << req_addr[1:0];
        wdata_nxt = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{req_wdata[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = req_wdata;
      end
    endcase
  end

  assign req_live = (state == IDLE) && req_valid && !flush;
  assign accept   = req_live && !misaligned;
  assign exc_adel = req_live && misaligned && !req_we;
  assign exc_ades = req_live && misaligned && req_we;
  assign stall    = accept || (state == BUSY);
  // Ack in the last allowed cycle beats the timeout.
  assign expire   = (state == BUSY) && !bus_ack && (cnt == CW'(TIMEOUT - 1));

  assign rsp_valid = (state == RESP) && !timed_out && !discard;
  assign exc_bus   = (state == RESP) && timed_out && !discard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (bus_ack || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      cnt         <= '0;
      timed_out   <= 1'b0;
      discard     <= 1'b0;
      addr_lo_q   <= '0;
      rsp_rdata   <= '0;
      rsp_addr_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
            cnt       <= '0;
            timed_out <= 1'b0;
            addr_lo_q <= req_addr[1:0];
          end
        end
        BUSY: begin
          // A flushed access still runs to completion on the bus; only its result is dropped.
          if (flush) discard <= 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!discard && !flush) begin
              rsp_rdata   <= bus_we ? 32'h0 : bus_rdata;
              rsp_addr_lo <= addr_lo_q;
            end
          end else if (expire) begin
            bus_req   <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          discard   <= 1'b0;
          timed_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl (TIMEOUT=4): vector table of loads/stores plus timeout, flush and reset sequences.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_addr_lo;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_bus;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr_lo(rsp_addr_lo),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  lo;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic        mis;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exc_bus_cyc = -1;
  logic [31:0] last_rdata = 32'h0;
  rsp_t        sb[$];
  rsp_t        mon_e;
  vec_t        vecs[11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every rsp_valid pulse must match the oldest pending expectation, in the expected cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid rdata %h expected no response (cycle %0d)", rsp_rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_addr_lo", {30'b0, rsp_addr_lo}, {30'b0, mon_e.lo});
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
    if (exc_bus) chk("exc_bus_cycle", cyc, exc_bus_cyc);
  end

  task automatic run_req(input vec_t v);
    int t;
    tick();
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    t = cyc;
    sample();
    if (v.mis) begin
      chk("exc_adel", {31'b0, exc_adel}, v.we ? 32'd0 : 32'd1);
      chk("exc_ades", {31'b0, exc_ades}, v.we ? 32'd1 : 32'd0);
      chk("stall_mis", {31'b0, stall}, 32'd0);
      tick();
      req_valid = 1'b0;
      sample();
      chk("bus_req_mis", {31'b0, bus_req}, 32'd0);
      return;
    end
    chk("exc_none", {30'b0, exc_adel, exc_ades}, 32'd0);
    chk("stall_accept", {31'b0, stall}, 32'd1);
    sb.push_back('{v.we ? 32'h0 : v.rdata, v.addr[1:0], t + 2 + v.waits});
    last_rdata = v.we ? 32'h0 : v.rdata;
    for (int w = 0; w <= v.waits; w++) begin
      tick();
      if (w == v.waits) begin
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
      end
      sample();
      chk("bus_req_busy", {31'b0, bus_req}, 32'd1);
      chk("stall_busy", {31'b0, stall}, 32'd1);
      if (w == 0) begin
        chk("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk("bus_be", {28'b0, bus_be}, {28'b0, v.be});
        chk("bus_we", {31'b0, bus_we}, {31'b0, v.we});
        if (v.we) chk("bus_wdata", bus_wdata, v.bwdata);
      end
    end
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    req_valid = 1'b0;
    sample();
    chk("stall_resp", {31'b0, stall}, 32'd0);
    chk("bus_req_resp", {31'b0, bus_req}, 32'd0);
    #1;
    chk("rsp_missing", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    int t;
    vec_t v;
    vecs[0]  = '{1'b0, 2'b10, 32'h0000_1004, 32'h0,         0, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 3, 32'hFFFF_0000, 4'b1000, 32'hA5A5_A5A5, 1'b0};
    vecs[2]  = '{1'b0, 2'b01, 32'h0000_1001, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         1'b1};
    vecs[3]  = '{1'b1, 2'b10, 32'h0000_1002, 32'h1111_2222, 0, 32'h0,         4'b0000, 32'h0,         1'b1};
    vecs[4]  = '{1'b0, 2'b00, 32'h0000_1002, 32'h0,         1, 32'h1122_3344, 4'b0100, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 2'b01, 32'h0000_1000, 32'hFFFF_5678, 0, 32'h0BAD_0BAD, 4'b0011, 32'h5678_5678, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 32'h0000_1006, 32'h0,         2, 32'hCAFE_F00D, 4'b1100, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 2'b11, 32'h0000_1008, 32'h89AB_CDEF, 0, 32'h0,         4'b1111, 32'h89AB_CDEF, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 32'h0000_100A, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 2'b00, 32'h0000_2000, 32'h1234_567F, 1, 32'h0,         4'b0001, 32'h7F7F_7F7F, 1'b0};
    vecs[10] = '{1'b0, 2'b01, 32'h0000_3003, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         1'b1};

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_exc_bus", {31'b0, exc_bus}, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_req(vecs[i]);

    // Timeout: no ack for 4 bus_req cycles.
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_4000;
    t = cyc;
    exc_bus_cyc = t + 5;
    sample();
    chk("to_stall", {31'b0, stall}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      sample();
      chk("to_bus_req", {31'b0, bus_req}, 32'd1);
      chk("to_stall_busy", {31'b0, stall}, 32'd1);
    end
    tick();
    req_valid = 1'b0;
    sample();
    chk("to_exc_bus", {31'b0, exc_bus}, 32'd1);
    chk("to_bus_req_off", {31'b0, bus_req}, 32'd0);
    chk("to_stall_resp", {31'b0, stall}, 32'd0);
    chk("to_rdata_hold", rsp_rdata, last_rdata);
    tick();
    sample();
    chk("to_exc_bus_off", {31'b0, exc_bus}, 32'd0);
    chk("to_stall_idle", {31'b0, stall}, 32'd0);
    exc_bus_cyc = -1;

    // Flush while BUSY: transaction completes, result discarded.
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_5000;
    sample();
    chk("fl_stall_t", {31'b0, stall}, 32'd1);
    tick();
    flush = 1'b1; req_valid = 1'b0;
    sample();
    chk("fl_stall_t1", {31'b0, stall}, 32'd1);
    chk("fl_bus_req_t1", {31'b0, bus_req}, 32'd1);
    tick();
    flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
    sample();
    chk("fl_stall_t2", {31'b0, stall}, 32'd1);
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    sample();
    chk("fl_stall_t3", {31'b0, stall}, 32'd0);
    chk("fl_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("fl_exc_bus", {31'b0, exc_bus}, 32'd0);
    chk("fl_bus_req_t3", {31'b0, bus_req}, 32'd0);

    // Flush in IDLE: request and misalignment both ignored.
    tick();
    req_valid = 1'b1; flush = 1'b1; req_size = 2'b10; req_addr = 32'h0000_6000;
    sample();
    chk("fi_stall", {31'b0, stall}, 32'd0);
    tick();
    req_addr = 32'h0000_6001;
    sample();
    chk("fi_exc", {30'b0, exc_adel, exc_ades}, 32'd0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    sample();
    chk("fi_bus_req", {31'b0, bus_req}, 32'd0);

    // Reset during BUSY.
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_7000;
    sample();
    tick();
    sample();
    chk("rb_bus_req", {31'b0, bus_req}, 32'd1);
    #2;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("rb_bus_req_async", {31'b0, bus_req}, 32'd0);
    chk("rb_stall_async", {31'b0, stall}, 32'd0);
    tick();
    tick();
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    sample();
    chk("rb_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rb_stall", {31'b0, stall}, 32'd0);
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    sample();
    chk("rb_exc_bus", {31'b0, exc_bus}, 32'd0);
    v = '{1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 0, 32'h0, 4'b1100, 32'h1234_1234, 1'b0};
    run_req(v);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
